// File: rtl/hocs_heartbeat_tx.sv
// hocs_heartbeat_tx: transmit end of the HOCS software-liveness heartbeat.
// Toggles heartbeat_signal once per accepted kick. A kick is accepted only
// with the right key and only after a cooldown window.
// Optional feature macro: HB_TX_BADKEY_LOCK_EN. When it is defined, a run of
// BAD_KEY_LIMIT consecutive bad keys forces LOCKED.
module hocs_heartbeat_tx #(
  parameter logic [15:0] KICK_KEY      = 16'hC0DE,
  parameter logic [15:0] MIN_GAP       = 16'd1000,
  parameter logic [3:0]  BAD_KEY_LIMIT = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        system_locked,
  input  logic        kick_valid,
  input  logic [15:0] kick_key,
  output logic        kick_ready,
  output logic        heartbeat_signal,
  output logic        kick_accepted,
  output logic        kick_rejected,
  output logic [1:0]  err_code,
  output logic [3:0]  bad_key_cnt,
  output logic [1:0]  tx_state
);

  localparam int unsigned GAP_W = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ARMED    = 2'b01,
    ST_COOLDOWN = 2'b10,
    ST_LOCKED   = 2'b11
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               heartbeat_q, heartbeat_d;
  logic               accepted_q, accepted_d;
  logic               rejected_q, rejected_d;
  logic [1:0]         err_q, err_d;
  logic [CNT_W-1:0]   bad_cnt_q, bad_cnt_d;

  logic               xfer;
  logic               key_ok;
  logic [CNT_W-1:0]   bad_cnt_inc;
  logic               lock_hit;

  assign kick_ready  = (state_q == ST_ARMED) || (state_q == ST_COOLDOWN);
  assign xfer        = kick_valid && kick_ready;
  assign key_ok      = (kick_key == KICK_KEY);
  assign bad_cnt_inc = (bad_cnt_q == {CNT_W{1'b1}}) ? bad_cnt_q : bad_cnt_q + CNT_W'(1);

`ifdef HB_TX_BADKEY_LOCK_EN
  assign lock_hit = (bad_cnt_inc == BAD_KEY_LIMIT);
`else
  logic unused_bad_key_limit;
  assign unused_bad_key_limit = ^BAD_KEY_LIMIT;
  assign lock_hit = 1'b0;
`endif

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      heartbeat_q <= 1'b0;
      accepted_q  <= 1'b0;
      rejected_q  <= 1'b0;
      err_q       <= 2'b00;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      heartbeat_q <= heartbeat_d;
      accepted_q  <= accepted_d;
      rejected_q  <= rejected_d;
      err_q       <= err_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  // Next-state logic; lockout outranks enable and kicks
  always_comb begin
    state_d = state_q;
    if (system_locked) begin
      state_d = ST_LOCKED;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (!enable)                     state_d = ST_IDLE;
          else if (xfer && key_ok)         state_d = ST_COOLDOWN;
          else if (xfer && lock_hit)       state_d = ST_LOCKED;
        end
        ST_COOLDOWN: begin
          if (!enable)                          state_d = ST_IDLE;
          else if (xfer && !key_ok && lock_hit) state_d = ST_LOCKED;
          else if (gap_cnt_q <= GAP_W'(1))      state_d = ST_ARMED;
        end
        default: state_d = ST_LOCKED;
      endcase
    end
  end

  // Datapath updates: heartbeat, pulses, error code, counters
  always_comb begin
    heartbeat_d = heartbeat_q;
    accepted_d  = 1'b0;
    rejected_d  = 1'b0;
    err_d       = err_q;
    bad_cnt_d   = bad_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    if (!system_locked) begin
      unique case (state_q)
        ST_IDLE: begin
          gap_cnt_d = '0;
        end
        ST_ARMED: begin
          if (!enable) begin
            gap_cnt_d = '0;
          end else if (xfer) begin
            if (key_ok) begin
              heartbeat_d = ~heartbeat_q;
              accepted_d  = 1'b1;
              bad_cnt_d   = '0;
              gap_cnt_d   = MIN_GAP;
            end else begin
              rejected_d = 1'b1;
              err_d      = 2'b01;
              bad_cnt_d  = bad_cnt_inc;
            end
          end
        end
        ST_COOLDOWN: begin
          if (!enable) begin
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = (gap_cnt_q == '0) ? '0 : gap_cnt_q - GAP_W'(1);
            if (xfer) begin
              rejected_d = 1'b1;
              if (key_ok) begin
                err_d = 2'b10;
              end else begin
                err_d     = 2'b11;
                bad_cnt_d = bad_cnt_inc;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign heartbeat_signal = heartbeat_q;
  assign kick_accepted    = accepted_q;
  assign kick_rejected    = rejected_q;
  assign err_code         = err_q;
  assign bad_key_cnt      = bad_cnt_q;
  assign tx_state         = state_q;

endmodule

// File: tb/tb_hocs_heartbeat_tx.sv
// Directed bench for hocs_heartbeat_tx (MIN_GAP=4, KICK_KEY=16'hC0DE).
module tb_hocs_heartbeat_tx;

  localparam logic [15:0] G = 16'hC0DE;
  localparam logic [15:0] B = 16'h1234;
`ifdef HB_TX_BADKEY_LOCK_EN
  localparam logic [3:0] LIMIT = 4'd2;
`else
  localparam logic [3:0] LIMIT = 4'd8;
`endif

  logic        clk = 1'b0;
  logic        rst_n, enable, system_locked, kick_valid;
  logic [15:0] kick_key;
  logic        kick_ready, heartbeat_signal, kick_accepted, kick_rejected;
  logic [1:0]  err_code, tx_state;
  logic [3:0]  bad_key_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  hocs_heartbeat_tx #(.KICK_KEY(G), .MIN_GAP(16'd4), .BAD_KEY_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .system_locked(system_locked),
    .kick_valid(kick_valid), .kick_key(kick_key), .kick_ready(kick_ready),
    .heartbeat_signal(heartbeat_signal), .kick_accepted(kick_accepted),
    .kick_rejected(kick_rejected), .err_code(err_code), .bad_key_cnt(bad_key_cnt),
    .tx_state(tx_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, e, l, v;
    logic [15:0] key;
    logic [1:0]  st;
    logic        rdy, hb, acc, rej;
    logic [1:0]  err;
    logic [3:0]  bkc;
  } vec_t;

  vec_t vecs[19];

  task automatic step(input logic r, input logic e, input logic l, input logic v,
                      input logic [15:0] k);
    rst_n = r; enable = e; system_locked = l; kick_valid = v; kick_key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic rdy,
                         input logic hb, input logic acc, input logic rej,
                         input logic [1:0] err, input logic [3:0] bkc);
    chk({tag, " tx_state"},         32'(tx_state),         32'(st));
    chk({tag, " kick_ready"},       32'(kick_ready),       32'(rdy));
    chk({tag, " heartbeat_signal"}, 32'(heartbeat_signal), 32'(hb));
    chk({tag, " kick_accepted"},    32'(kick_accepted),    32'(acc));
    chk({tag, " kick_rejected"},    32'(kick_rejected),    32'(rej));
    chk({tag, " err_code"},         32'(err_code),         32'(err));
    chk({tag, " bad_key_cnt"},      32'(bad_key_cnt),      32'(bkc));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; system_locked = 1'b0; kick_valid = 1'b0; kick_key = '0;

    //            r     e     l     v     key    st     rdy   hb    acc   rej   err    bkc
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 4'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, B,     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd1};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 4'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, G,     2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 4'd0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, G,     2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 1'b1, B,     2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].r, vecs[i].e, vecs[i].l, vecs[i].v, vecs[i].key);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].rdy, vecs[i].hb, vecs[i].acc,
              vecs[i].rej, vecs[i].err, vecs[i].bkc);
    end

    // Consecutive bad keys in ARMED, then a good kick
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk_all("bad1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
`ifdef HB_TX_BADKEY_LOCK_EN
    chk_all("bad2", 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk_all("bad3", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, G);
    chk_all("badgood", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2);
`else
    chk_all("bad2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk_all("bad3", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1, G);
    chk_all("badgood", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'd0);

    // Saturation of bad_key_cnt at 15
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk("sat14 bad_key_cnt", 32'(bad_key_cnt), 32'd14);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk("sat15 bad_key_cnt", 32'(bad_key_cnt), 32'd15);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk_all("sat16", 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 4'd15);
`endif

    // Lockout mid-cooldown freezes the heartbeat until reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, G);
    chk_all("lk_acc", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, G);
    chk_all("lk_hit", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b1, G);
    chk_all("lk_hold", 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk_all("lk_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);

    // Reset mid-cooldown, then immediate re-arm and accept
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, G);
    step(1'b1, 1'b1, 1'b0, 1'b1, B);
    chk_all("cd_rej", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk_all("cd_rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("rearm tx_state", 32'(tx_state), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, G);
    chk_all("rearm_acc", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("pulse_len kick_accepted", 32'(kick_accepted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
